// File: rtl/traffic_light_pkg.sv
// rtl/traffic_light_pkg.sv - shared debounce constants and state encoding
// Purpose: holds the per-key debounce FSM encoding and the default debounce
//          length used by key_debounce and key_request_conditioner.
// Ports:   none (package).
package traffic_light_pkg;

    // 20 ms of stable level at 50 MHz.
    localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;

    typedef enum logic [1:0] {
        DB_IDLE         = 2'd0,
        DB_PRESS_WAIT   = 2'd1,
        DB_HELD         = 2'd2,
        DB_RELEASE_WAIT = 2'd3
    } db_state_e;

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - one key: synchronizer, debounce FSM and counter
// Purpose: turns one raw active-low bouncing push-button into a clean
//          active-high level plus a single-clock strobe per accepted press.
// Ports:   clk_i          system clock
//          rst_i          asynchronous active-high reset
//          key_n_i        raw asynchronous key, 0 = pressed
//          pressed_o      debounced level, 1 = held
//          press_pulse_o  one-clock strobe when a press is accepted
module key_debounce
    import traffic_light_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic key_n_i,
    output logic pressed_o,
    output logic press_pulse_o
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);

    // sync_q[0] is the metastability-catching flop; both hold the raw
    // (active-low) level, so reset to 1 means "released".
    logic [1:0]       sync_q;
    logic             synced;
    db_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             pulse_q, pulse_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], key_n_i};
        end
    end

    assign synced = ~sync_q[1];

    // Saturating increment: the counter must never wrap back to zero.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        case (state_q)
            DB_IDLE: begin
                if (synced) begin
                    state_d = DB_PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            DB_PRESS_WAIT: begin
                if (!synced) begin
                    state_d = DB_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DB_HELD;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            DB_HELD: begin
                if (!synced) begin
                    state_d = DB_RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            DB_RELEASE_WAIT: begin
                // A bounce back to pressed returns to HELD silently, so one
                // physical press never yields a second strobe.
                if (synced) begin
                    state_d = DB_HELD;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DB_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = DB_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= DB_IDLE;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign pressed_o     = (state_q == DB_HELD) || (state_q == DB_RELEASE_WAIT);
    assign press_pulse_o = pulse_q;

endmodule

// File: rtl/key_request_conditioner.sv
// rtl/key_request_conditioner.sv - debounced car-arrival keys with sticky requests
// Purpose: debounces NUM_KEYS car-arrival keys and holds a sticky request per
//          key until the traffic-light controller acknowledges it.
// Ports:   CLOCK_50     50 MHz system clock
//          RESET        asynchronous active-high reset
//          KEY          raw active-low keys (bit 0 West, bit 1 East)
//          ACK          controller acknowledge, one bit per key
//          PRESSED      debounced key level, 1 = held
//          PRESS_PULSE  one-clock strobe per accepted press
//          REQ          sticky car-arrival request
module key_request_conditioner
    import traffic_light_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int NUM_KEYS        = 2
) (
    input  logic                CLOCK_50,
    input  logic                RESET,
    input  logic [NUM_KEYS-1:0] KEY,
    input  logic [NUM_KEYS-1:0] ACK,
    output logic [NUM_KEYS-1:0] PRESSED,
    output logic [NUM_KEYS-1:0] PRESS_PULSE,
    output logic [NUM_KEYS-1:0] REQ
);

    logic [NUM_KEYS-1:0] req_q, req_d;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_key_debounce (
            .clk_i        (CLOCK_50),
            .rst_i        (RESET),
            .key_n_i      (KEY[i]),
            .pressed_o    (PRESSED[i]),
            .press_pulse_o(PRESS_PULSE[i])
        );
    end

    // Clearing first and then OR-ing the strobe makes a coincident new
    // arrival win over the acknowledge; ACK on an idle bit is a no-op.
    assign req_d = (req_q & ~ACK) | PRESS_PULSE;

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            req_q <= '0;
        end else begin
            req_q <= req_d;
        end
    end

    assign REQ = req_q;

endmodule

// File: tb/tb_key_request_conditioner.sv
// tb/tb_key_request_conditioner.sv - scoreboard bench for key_request_conditioner
module tb_key_request_conditioner;

    localparam int D  = 4;
    localparam int NK = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NK-1:0] key = '1;
    logic [NK-1:0] ack = '0;
    logic [NK-1:0] pressed, pulse, req;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    logic [5:0] exp_q[$];

    // Reference model: raw key delayed two samples, level flips after D+1
    // consecutive samples disagreeing with the accepted level.
    logic [NK-1:0] m_s1  = '1;
    logic [NK-1:0] m_s2  = '1;
    logic [NK-1:0] m_lvl = '0;
    logic [NK-1:0] m_pulse = '0;
    logic [NK-1:0] m_req = '0;
    int            m_run[NK];

    key_request_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .NUM_KEYS       (NK)
    ) dut (
        .CLOCK_50   (clk),
        .RESET      (rst),
        .KEY        (key),
        .ACK        (ack),
        .PRESSED    (pressed),
        .PRESS_PULSE(pulse),
        .REQ        (req)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    function automatic void model_edge(input logic [NK-1:0] k, input logic [NK-1:0] a, input logic r);
        logic [NK-1:0] req_new;
        logic [NK-1:0] p;
        logic          smp;
        if (r) begin
            m_s1 = '1; m_s2 = '1; m_lvl = '0; m_pulse = '0; m_req = '0;
            for (int i = 0; i < NK; i++) m_run[i] = 0;
            return;
        end
        req_new = (m_req & ~a) | m_pulse;
        p = '0;
        for (int i = 0; i < NK; i++) begin
            smp = ~m_s2[i];
            if (smp == m_lvl[i]) m_run[i] = 0;
            else                 m_run[i] = m_run[i] + 1;
            if (m_run[i] == D + 1) begin
                m_lvl[i] = smp;
                m_run[i] = 0;
                p[i]     = smp;
            end
        end
        m_pulse = p;
        m_s2    = m_s1;
        m_s1    = k;
        m_req   = req_new;
    endfunction

    // Drives inputs for the next rising edge and queues what that edge must produce.
    task automatic step(input logic [NK-1:0] k, input logic [NK-1:0] a, input logic r);
        @(negedge clk);
        key = k; ack = a; rst = r;
        model_edge(k, a, r);
        exp_q.push_back({m_lvl, m_pulse, m_req});
        if (r) begin
            #1;
            check("async_reset", {pressed, pulse, req}, 6'b0);
        end
    endtask

    // Key pattern k held from the first driven edge: strobe only after edge +D+2.
    task automatic latency_check(input string name, input logic [NK-1:0] k, input logic [NK-1:0] exp);
        repeat (D + 2) step(k, '0, 1'b0);
        @(posedge clk); #2;
        check({name, "_early"}, {4'b0, pulse}, 6'b0);
        step(k, '0, 1'b0);
        @(posedge clk); #2;
        check(name, {4'b0, pulse}, {4'b0, exp});
    endtask

    initial begin : monitor
        logic [5:0] e;
        forever begin
            @(posedge clk); #1;
            cycle++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("scoreboard", {pressed, pulse, req}, e);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin : driver
        int            run_left[NK];
        logic [NK-1:0] lvl_r;
        logic [NK-1:0] ack_r;
        for (int i = 0; i < NK; i++) run_left[i] = 0;
        lvl_r = '1;

        repeat (2) step('1, '0, 1'b1);
        repeat (3) step('1, '0, 1'b0);

        // West press held: strobe after edge k+6, then request and level stay.
        latency_check("west_latency", 2'b10, 2'b01);
        repeat (4) step(2'b10, '0, 1'b0);

        // East glitch of 3 clocks is rejected.
        repeat (3) step(2'b00, '0, 1'b0);
        repeat (8) step(2'b10, '0, 1'b0);

        // Acknowledge clears West; acknowledge on idle East is ignored.
        step(2'b10, 2'b01, 1'b0);
        repeat (2) step(2'b10, '0, 1'b0);
        step(2'b10, 2'b10, 1'b0);
        repeat (8) step(2'b11, '0, 1'b0);

        // ACK coincident with the strobe: new arrival wins.
        repeat (12) step(2'b10, {1'b0, m_pulse[0]}, 1'b0);
        repeat (8) step(2'b11, '0, 1'b0);

        // Reset mid-qualification discards the pending press.
        repeat (3) step(2'b10, '0, 1'b0);
        repeat (2) step(2'b10, '0, 1'b1);
        latency_check("post_reset_latency", 2'b10, 2'b01);
        repeat (8) step(2'b11, '0, 1'b0);

        // Simultaneous presses.
        latency_check("both_latency", 2'b00, 2'b11);
        step(2'b00, '0, 1'b0);
        @(posedge clk); #2;
        check("both_req", {4'b0, req}, 6'b000011);
        repeat (8) step(2'b11, 2'b11, 1'b0);

        // Randomized bouncing keys, acknowledges and occasional resets.
        for (int n = 0; n < 700; n++) begin
            for (int i = 0; i < NK; i++) begin
                if (run_left[i] == 0) begin
                    lvl_r[i]    = 1'($urandom_range(0, 1));
                    run_left[i] = $urandom_range(1, D + 5);
                end
                run_left[i]--;
                ack_r[i] = ($urandom_range(0, 3) == 0);
            end
            step(lvl_r, ack_r, ($urandom_range(0, 149) == 0));
        end
        step('1, '0, 1'b0);

        repeat (3) @(posedge clk);
        #3;
        check("queue_drained", 6'(exp_q.size()), 6'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/key_request_conditioner.md
KEY_REQUEST_CONDITIONER -- requirements
Module: key_request_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, meaning the number of stable clocks required to accept a level change (20 ms at 50 MHz).
REQ-002 SHALL have parameter NUM_KEYS, default 2, meaning the number of car-arrival keys (bit 0 = West, bit 1 = East).
REQ-003 SHALL have a single clock and an asynchronous, active-high reset, stated in REQ-004 and REQ-005.
REQ-004 CLOCK_50  input  1  50 MHz system clock; all state changes on its rising edge.
REQ-005 RESET  input  1  asynchronous, active-high reset.
REQ-006 KEY  input  NUM_KEYS  raw, asynchronous, bouncing push-buttons; active-low (0 = pressed).
REQ-007 ACK  input  NUM_KEYS  controller acknowledge; one bit per key, sampled each clock.
REQ-008 PRESSED  output  NUM_KEYS  debounced key level (1 = held).
REQ-009 PRESS_PULSE  output  NUM_KEYS  one-clock strobe on an accepted press.
REQ-010 REQ  output  NUM_KEYS  sticky car-arrival request to the traffic-light controller.

Function
REQ-011 Each KEY bit SHALL pass through a 2-flop synchronizer, inverted to active-high, before any other logic uses it.
REQ-012 Each key SHALL have an independent FSM with states IDLE, PRESS_WAIT, HELD and RELEASE_WAIT, plus a counter of width clog2(DEBOUNCE_CYCLES+1).
REQ-013 In IDLE, synced=1 SHALL move the FSM to PRESS_WAIT and clear the counter.
REQ-014 In PRESS_WAIT, synced=0 SHALL return the FSM to IDLE.
REQ-015 In PRESS_WAIT, with synced=1 and counter = DEBOUNCE_CYCLES-1, the FSM SHALL move to HELD and assert PRESS_PULSE for exactly one clock; otherwise the counter SHALL increment.
REQ-016 In HELD, synced=0 SHALL move the FSM to RELEASE_WAIT and clear the counter.
REQ-017 In RELEASE_WAIT, synced=1 SHALL return the FSM to HELD with no pulse.
REQ-018 In RELEASE_WAIT, counter = DEBOUNCE_CYCLES-1 SHALL move the FSM to IDLE; otherwise the counter SHALL increment.
REQ-019 PRESSED SHALL be 1 in states HELD and RELEASE_WAIT, and 0 otherwise.
REQ-020 Latency: for KEY low and stable from the sampling edge k, PRESS_PULSE SHALL be high during the cycle after edge k+2+DEBOUNCE_CYCLES.
REQ-021 A glitch shorter than DEBOUNCE_CYCLES clocks SHALL produce no pulse and no change on PRESSED.
REQ-022 REQ[i] SHALL set on PRESS_PULSE[i] and clear on ACK[i] while REQ[i]=1; ACK[i] while REQ[i]=0 SHALL be ignored.
REQ-023 If PRESS_PULSE[i] and ACK[i] occur in the same cycle, REQ[i] SHALL remain 1 (the new arrival wins).
REQ-024 A repeated press while REQ[i]=1 SHALL leave REQ[i]=1 and SHALL NOT be counted.
REQ-025 Keys SHALL be fully independent; simultaneous presses SHALL set both REQ bits in the same cycle.
REQ-026 Holding a key indefinitely SHALL yield exactly one PRESS_PULSE.
REQ-027 The counter SHALL saturate and never wrap.

Reset
REQ-028 RESET=1 SHALL immediately force, without waiting for a clock edge: all FSMs to IDLE, counters to 0, synchronizer flops to 1 (released), PRESSED=0, PRESS_PULSE=0 and REQ=0.
REQ-029 Reset asserted mid-debounce SHALL discard the pending press; after deassertion, a still-held key SHALL need a full DEBOUNCE_CYCLES qualification again.
REQ-030 Reset deassertion SHALL take effect on the first rising CLOCK_50 edge after RESET falls.

Structure
REQ-031 Package traffic_light_pkg SHALL hold the debounce state encoding and the DEBOUNCE_CYCLES default constant.
REQ-032 Sub-module key_debounce SHALL implement one key's synchronizer, FSM and counter.
REQ-033 key_debounce SHALL be instantiated NUM_KEYS times by generate.
REQ-034 The REQ/ACK latch SHALL live in the top level.

Verification (DEBOUNCE_CYCLES=4)
REQ-035 KEY[0] low from edge 10, held -> PRESS_PULSE[0] high only in the cycle after edge 16; REQ[0]=1 and PRESSED[0]=1 thereafter.
REQ-036 KEY[1] low for 3 clocks then high -> PRESS_PULSE[1], PRESSED[1] and REQ[1] stay 0.
REQ-037 REQ[0]=1, then ACK[0] pulse -> REQ[0]=0 next cycle; ACK[1] pulse while REQ[1]=0 -> no change.
REQ-038 ACK[0] coincident with PRESS_PULSE[0] -> REQ[0] remains 1.
REQ-039 RESET=1 for 2 clocks mid-PRESS_WAIT with KEY[0] still low -> all outputs 0 asynchronously; pulse after edge reset_release+6.
REQ-040 Both keys pressed on the same edge -> both PRESS_PULSE bits high in the same cycle and REQ=2'b11.
